dino_motion_ctrl: RTL and testbench

Frame-synchronous motion and game-state sequencer for the dino game. It replaces the software jump loop: it debounces the `jump` button and steps the dino's vertical position once per video frame with integer gravity. It also maintains run/game-over state and a frame score. It sits between the button input, the VGA controller's end-of-screen pulse and the sprite renderer, which consumes `dino_y`, `jump_height` and `game_over`.

---
 rtl/dino_pkg.sv | 26 ++
 rtl/dino_debounce.sv | 58 +++++
 rtl/dino_motion_ctrl.sv | 152 +++++++++++++++
 tb/tb_dino_motion_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// dino_pkg: shared types and default screen/physics constants for the dino game.
//   motion_state_t : vertical motion FSM states (grounded / in the air)
//   game_state_t   : game FSM states (running / game over)
//   SCREEN_W/H     : visible resolution of the VGA frame
//   GROUND_Y       : y of the dino's bottom edge when standing on the ground
//   JUMP_V         : launch velocity in pixels per frame
//   GRAVITY        : velocity decrement applied every airborne frame
package dino_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        AIR  = 1'b1
    } motion_state_t;

    typedef enum logic {
        RUN  = 1'b0,
        OVER = 1'b1
    } game_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int GROUND_Y = 400;
    localparam int JUMP_V   = 12;
    localparam int GRAVITY  = 1;

endpackage

// File: rtl/dino_debounce.sv
// dino_debounce: synchronizes and debounces the raw jump button.
//   clk, reset : system clock, synchronous active-high reset
//   button     : raw asynchronous button level
//   rise       : one-cycle pulse when the debounced level goes 0 -> 1
// The debounced level only follows the synchronized input after it has
// disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle
// (a bounce back) restarts the count.
module dino_debounce
    import dino_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/dino_motion_ctrl.sv
// dino_motion_ctrl: frame-synchronous jump physics and game-state sequencer.
//   clk, reset  : system clock, synchronous active-high reset
//   jump        : raw button level (debounced internally)
//   frame_tick  : one-cycle end-of-screen pulse; motion and score step on it
//   collide     : dino/obstacle overlap, only looked at on frame_tick
//   dino_y      : y of the dino's bottom edge
//   jump_height : GROUND_Y - dino_y
//   airborne    : motion FSM is in AIR
//   game_over   : game FSM is in OVER
//   score       : frames survived, saturating at 0xFFFF
//   update_done : pulses the cycle after frame_tick, once outputs are updated
module dino_motion_ctrl
    import dino_pkg::*;
#(
    parameter int Y_W             = 10,
    parameter int GROUND_Y        = dino_pkg::GROUND_Y,
    parameter int JUMP_V          = dino_pkg::JUMP_V,
    parameter int GRAVITY         = dino_pkg::GRAVITY,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           jump,
    input  logic           frame_tick,
    input  logic           collide,
    output logic [Y_W-1:0] dino_y,
    output logic [Y_W-1:0] jump_height,
    output logic           airborne,
    output logic           game_over,
    output logic [15:0]    score,
    output logic           update_done
);

    localparam logic [Y_W-1:0]        GROUND_U  = Y_W'(GROUND_Y);
    localparam logic signed [Y_W+1:0] GROUND_S  = (Y_W+2)'(GROUND_Y);
    localparam logic signed [7:0]     JUMP_V_S  = 8'(JUMP_V);
    localparam logic signed [7:0]     GRAVITY_S = 8'(GRAVITY);

    logic press;

    dino_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .button(jump),
        .rise  (press)
    );

    motion_state_t         motion_q, motion_d;
    game_state_t           game_q,   game_d;
    logic [Y_W-1:0]        y_q,      y_d;
    logic signed [7:0]     v_q,      v_d;
    logic [15:0]           score_q,  score_d;
    logic                  pending_q, pending_d;
    logic [Y_W-1:0]        jump_height_q;
    logic                  airborne_q, game_over_q, update_done_q;
    logic signed [Y_W+1:0] y_next;

    // Next-state logic for both FSMs, the physics and the score. Collision
    // is checked before motion so a collide tick freezes the pre-tick y even
    // if that tick would have landed the dino.
    always_comb begin
        motion_d  = motion_q;
        game_d    = game_q;
        y_d       = y_q;
        v_d       = v_q;
        score_d   = score_q;
        pending_d = pending_q;
        y_next    = $signed({2'b00, y_q}) - (Y_W+2)'(v_q);

        if (game_q == OVER) begin
            // The restarting press only restarts; it never queues a jump.
            if (press) begin
                game_d    = RUN;
                motion_d  = IDLE;
                y_d       = GROUND_U;
                v_d       = '0;
                score_d   = '0;
                pending_d = 1'b0;
            end
        end else begin
            // Presses are only remembered while grounded: no double jump.
            if (press && motion_q == IDLE) begin
                pending_d = 1'b1;
            end
            if (frame_tick) begin
                if (collide) begin
                    game_d = OVER;
                end else begin
                    if (score_q != 16'hFFFF) begin
                        score_d = score_q + 16'd1;
                    end
                    if (motion_q == IDLE) begin
                        if (pending_d) begin
                            motion_d  = AIR;
                            v_d       = JUMP_V_S;
                            pending_d = 1'b0;
                        end
                    end else begin
                        v_d = v_q - GRAVITY_S;
                        if (y_next >= GROUND_S) begin
                            motion_d = IDLE;
                            y_d      = GROUND_U;
                            v_d      = '0;
                        end else if (y_next[Y_W+1]) begin
                            // Off the top of the screen: pin y, velocity keeps integrating.
                            y_d = '0;
                        end else begin
                            y_d = y_next[Y_W-1:0];
                        end
                    end
                end
            end
        end
    end

    // Single state register; all outputs are registered from next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            motion_q      <= IDLE;
            game_q        <= RUN;
            y_q           <= GROUND_U;
            v_q           <= '0;
            score_q       <= '0;
            pending_q     <= 1'b0;
            jump_height_q <= '0;
            airborne_q    <= 1'b0;
            game_over_q   <= 1'b0;
            update_done_q <= 1'b0;
        end else begin
            motion_q      <= motion_d;
            game_q        <= game_d;
            y_q           <= y_d;
            v_q           <= v_d;
            score_q       <= score_d;
            pending_q     <= pending_d;
            jump_height_q <= GROUND_U - y_d;
            airborne_q    <= (motion_d == AIR);
            game_over_q   <= (game_d == OVER);
            update_done_q <= frame_tick;
        end
    end

    assign dino_y      = y_q;
    assign jump_height = jump_height_q;
    assign airborne    = airborne_q;
    assign game_over   = game_over_q;
    assign score       = score_q;
    assign update_done = update_done_q;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// tb_dino_motion_ctrl: directed self-checking bench for dino_motion_ctrl
// with a short debounce window so presses settle within a few cycles.
module tb_dino_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       jump;
    logic       frame_tick;
    logic       collide;
    logic [9:0] dino_y;
    logic [9:0] jump_height;
    logic       airborne;
    logic       game_over;
    logic [15:0] score;
    logic       update_done;

    int tests_run = 0;
    int fails     = 0;
    int exp_score = 0;
    bit count_score = 1'b1;
    logic ud_seen, ud_after;

    // Expected dino_y after launch tick (index 0) and the following 25 ticks.
    int ys[26] = '{400, 388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322,
                   322, 323, 325, 328, 332, 337, 343, 350, 358, 367, 377, 388, 400};

    dino_motion_ctrl #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .jump       (jump),
        .frame_tick (frame_tick),
        .collide    (collide),
        .dino_y     (dino_y),
        .jump_height(jump_height),
        .airborne   (airborne),
        .game_over  (game_over),
        .score      (score),
        .update_done(update_done)
    );

    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame tick; also tracks the expected score while the game runs.
    task automatic tick(input logic col);
        collide    = col;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        collide    = 1'b0;
        ud_seen    = update_done;
        if (count_score && !col && exp_score < 65535) exp_score++;
        if (col) count_score = 1'b0;
        @(negedge clk);
        ud_after = update_done;
    endtask

    task automatic press_release();
        jump = 1'b1;
        wait_cycles(10);
        jump = 1'b0;
        wait_cycles(10);
    endtask

    task automatic test_reset();
        tests_run++; if (dino_y !== 10'd400) begin fails++; $display("[TB] FAIL reset_y: got %0d expected 400", dino_y); end
        tests_run++; if (jump_height !== 10'd0) begin fails++; $display("[TB] FAIL reset_jh: got %0d expected 0", jump_height); end
        tests_run++; if (airborne !== 1'b0) begin fails++; $display("[TB] FAIL reset_air: got %b expected 0", airborne); end
        tests_run++; if (game_over !== 1'b0) begin fails++; $display("[TB] FAIL reset_over: got %b expected 0", game_over); end
        tests_run++; if (score !== 16'd0) begin fails++; $display("[TB] FAIL reset_score: got %0d expected 0", score); end
        tests_run++; if (update_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_ud: got %b expected 0", update_done); end
    endtask

    task automatic test_idle_ticks();
        int pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            if (ud_seen === 1'b1 && ud_after === 1'b0) pulses++;
        end
        tests_run++; if (pulses != 10) begin fails++; $display("[TB] FAIL idle_ud_pulses: got %0d expected 10", pulses); end
        tests_run++; if (score !== 16'd10) begin fails++; $display("[TB] FAIL idle_score: got %0d expected 10", score); end
        tests_run++; if (dino_y !== 10'd400) begin fails++; $display("[TB] FAIL idle_y: got %0d expected 400", dino_y); end
        tests_run++; if (airborne !== 1'b0) begin fails++; $display("[TB] FAIL idle_air: got %b expected 0", airborne); end
    endtask

    task automatic test_jump_profile();
        press_release();
        tick(1'b0);
        tests_run++; if (dino_y !== 10'd400) begin fails++; $display("[TB] FAIL launch_y: got %0d expected 400", dino_y); end
        tests_run++; if (airborne !== 1'b1) begin fails++; $display("[TB] FAIL launch_air: got %b expected 1", airborne); end
        for (int k = 1; k <= 26; k++) begin
            int ey;
            tick(1'b0);
            ey = (k <= 25) ? ys[k] : 400;
            tests_run++; if (dino_y !== 10'(ey)) begin fails++; $display("[TB] FAIL profile_y tick %0d: got %0d expected %0d", k, dino_y, ey); end
            tests_run++; if (jump_height !== 10'(400 - ey)) begin fails++; $display("[TB] FAIL profile_jh tick %0d: got %0d expected %0d", k, jump_height, 400 - ey); end
            if (k == 12) begin
                tests_run++; if (jump_height !== 10'd78) begin fails++; $display("[TB] FAIL peak_jh: got %0d expected 78", jump_height); end
            end
            if (k == 24) begin
                tests_run++; if (airborne !== 1'b1) begin fails++; $display("[TB] FAIL air_before_land: got %b expected 1", airborne); end
            end
            if (k >= 25) begin
                tests_run++; if (airborne !== 1'b0) begin fails++; $display("[TB] FAIL air_after_land tick %0d: got %b expected 0", k, airborne); end
            end
        end
        tests_run++; if (score !== 16'(exp_score)) begin fails++; $display("[TB] FAIL jump_score: got %0d expected %0d", score, exp_score); end
    endtask

    task automatic test_bounce();
        jump = 1'b1; wait_cycles(2);
        jump = 1'b0; wait_cycles(1);
        jump = 1'b1; wait_cycles(3);
        jump = 1'b0; wait_cycles(2);
        jump = 1'b1; wait_cycles(1);
        jump = 1'b0; wait_cycles(10);
        tick(1'b0);
        tests_run++; if (airborne !== 1'b0) begin fails++; $display("[TB] FAIL bounce_only_launch: got %b expected 0", airborne); end
        jump = 1'b1; wait_cycles(2);
        jump = 1'b0; wait_cycles(1);
        jump = 1'b1; wait_cycles(12);
        jump = 1'b0; wait_cycles(10);
        tick(1'b0);
        tests_run++; if (airborne !== 1'b1) begin fails++; $display("[TB] FAIL bounce_launch: got %b expected 1", airborne); end
        for (int i = 1; i <= 3; i++) tick(1'b0);
        tests_run++; if (dino_y !== 10'd367) begin fails++; $display("[TB] FAIL bounce_tick3_y: got %0d expected 367", dino_y); end
        press_release();
        for (int i = 4; i <= 28; i++) begin
            tick(1'b0);
            if (i == 25) begin
                tests_run++; if (dino_y !== 10'd400) begin fails++; $display("[TB] FAIL bounce_land_y: got %0d expected 400", dino_y); end
            end
        end
        tests_run++; if (airborne !== 1'b0) begin fails++; $display("[TB] FAIL no_buffered_jump: got %b expected 0", airborne); end
        tests_run++; if (dino_y !== 10'd400) begin fails++; $display("[TB] FAIL bounce_final_y: got %0d expected 400", dino_y); end
    endtask

    task automatic test_collide();
        logic [15:0] frozen_score;
        press_release();
        tick(1'b0);
        for (int i = 1; i <= 4; i++) tick(1'b0);
        frozen_score = 16'(exp_score);
        tick(1'b1);
        tests_run++; if (game_over !== 1'b1) begin fails++; $display("[TB] FAIL collide_over: got %b expected 1", game_over); end
        tests_run++; if (dino_y !== 10'd358) begin fails++; $display("[TB] FAIL collide_y: got %0d expected 358", dino_y); end
        tests_run++; if (score !== frozen_score) begin fails++; $display("[TB] FAIL collide_score: got %0d expected %0d", score, frozen_score); end
        for (int i = 0; i < 3; i++) tick(1'b0);
        tests_run++; if (ud_seen !== 1'b1) begin fails++; $display("[TB] FAIL over_ud: got %b expected 1", ud_seen); end
        tests_run++; if (dino_y !== 10'd358) begin fails++; $display("[TB] FAIL over_y_frozen: got %0d expected 358", dino_y); end
        tests_run++; if (score !== frozen_score) begin fails++; $display("[TB] FAIL over_score_frozen: got %0d expected %0d", score, frozen_score); end
        tests_run++; if (game_over !== 1'b1) begin fails++; $display("[TB] FAIL over_stays: got %b expected 1", game_over); end
    endtask

    task automatic test_restart();
        jump = 1'b1;
        wait_cycles(10);
        exp_score   = 0;
        count_score = 1'b1;
        tests_run++; if (game_over !== 1'b0) begin fails++; $display("[TB] FAIL restart_over: got %b expected 0", game_over); end
        tests_run++; if (dino_y !== 10'd400) begin fails++; $display("[TB] FAIL restart_y: got %0d expected 400", dino_y); end
        tests_run++; if (score !== 16'd0) begin fails++; $display("[TB] FAIL restart_score: got %0d expected 0", score); end
        tests_run++; if (jump_height !== 10'd0) begin fails++; $display("[TB] FAIL restart_jh: got %0d expected 0", jump_height); end
        jump = 1'b0;
        wait_cycles(10);
        tick(1'b0);
        tests_run++; if (airborne !== 1'b0) begin fails++; $display("[TB] FAIL restart_no_launch: got %b expected 0", airborne); end
        tests_run++; if (score !== 16'd1) begin fails++; $display("[TB] FAIL restart_tick_score: got %0d expected 1", score); end
    endtask

    task automatic test_reset_midjump();
        press_release();
        tick(1'b0);
        for (int i = 1; i <= 6; i++) tick(1'b0);
        tests_run++; if (dino_y !== 10'd343) begin fails++; $display("[TB] FAIL midjump_y: got %0d expected 343", dino_y); end
        reset      = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        frame_tick = 1'b0;
        exp_score  = 0;
        tests_run++; if (dino_y !== 10'd400) begin fails++; $display("[TB] FAIL rst_mid_y: got %0d expected 400", dino_y); end
        tests_run++; if (jump_height !== 10'd0) begin fails++; $display("[TB] FAIL rst_mid_jh: got %0d expected 0", jump_height); end
        tests_run++; if (airborne !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_air: got %b expected 0", airborne); end
        tests_run++; if (game_over !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_over: got %b expected 0", game_over); end
        tests_run++; if (score !== 16'd0) begin fails++; $display("[TB] FAIL rst_mid_score: got %0d expected 0", score); end
        tests_run++; if (update_done !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_ud: got %b expected 0", update_done); end
        wait_cycles(2);
        press_release();
        tick(1'b0);
        tests_run++; if (airborne !== 1'b1) begin fails++; $display("[TB] FAIL post_rst_launch: got %b expected 1", airborne); end
        tick(1'b0);
        tests_run++; if (dino_y !== 10'd388) begin fails++; $display("[TB] FAIL post_rst_y: got %0d expected 388", dino_y); end
        tests_run++; if (score !== 16'd2) begin fails++; $display("[TB] FAIL post_rst_score: got %0d expected 2", score); end
    endtask

    initial begin
        reset      = 1'b1;
        jump       = 1'b0;
        frame_tick = 1'b0;
        collide    = 1'b0;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(1);
        test_reset();
        test_idle_ticks();
        test_jump_profile();
        test_bounce();
        test_collide();
        test_restart();
        test_reset_midjump();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
